// File: rtl/cache_lookup_ctrl.sv
// Per-core cache lookup controller: reads the directory, checks tag/state, serves hits and sequences memory commands on misses and upgrades.
// Latency: hit response 2 cycles after acceptance (3 for a store hit in E); miss paths add the memory command round trips.
// Backpressure: one transaction in flight (req_ready only in IDLE); mem_valid and rsp_valid hold until mem_ready / rsp_ready.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   req_*              core request (valid/ready, address, store flag)
//   rsp_*              core response (valid/ready, hit flag)
//   dir_*              directory port: index/next_tag/next_state/write out, current_tag/current_state in (1-cycle read)
//   mem_*              memory/coherence command (valid/ready, cmd, line address), completion pulse and exclusive grant
module cache_lookup_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 5,
  parameter int INDEX_WIDTH  = 7,
  parameter int TAG_WIDTH    = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   req_write,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_hit,
  output logic [INDEX_WIDTH-1:0] dir_index,
  output logic [TAG_WIDTH-1:0]   dir_next_tag,
  output logic [1:0]             dir_next_state,
  output logic                   dir_write,
  input  logic [TAG_WIDTH-1:0]   dir_current_tag,
  input  logic [1:0]             dir_current_state,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [1:0]             mem_cmd,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_done,
  input  logic                   mem_excl
);

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  localparam logic [1:0] CMD_READ_S    = 2'd0;
  localparam logic [1:0] CMD_READ_X    = 2'd1;
  localparam logic [1:0] CMD_UPGRADE   = 2'd2;
  localparam logic [1:0] CMD_WRITEBACK = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CMP,
    CMD,
    WAIT,
    UPDATE,
    RESP
  } fsm_t;

  fsm_t                   state, state_nxt;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic                   write_q;
  logic                   hit_q, hit_nxt;
  logic [1:0]             cmd_q, cmd_nxt;
  logic [1:0]             nst_q, nst_nxt;
  logic [ADDR_WIDTH-1:0]  maddr_q, maddr_nxt;

  logic [ADDR_WIDTH-1:0]  line_addr;
  logic [ADDR_WIDTH-1:0]  victim_addr;
  logic [1:0]             fill_cmd;
  logic                   line_hit;

  // Offset bits never matter to a line-granular controller.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

  assign line_addr   = {tag_q, idx_q, {OFFSET_WIDTH{1'b0}}};
  assign victim_addr = {dir_current_tag, idx_q, {OFFSET_WIDTH{1'b0}}};
  assign fill_cmd    = write_q ? CMD_READ_X : CMD_READ_S;
  assign line_hit    = (dir_current_state != ST_I) && (dir_current_tag == tag_q);

  // Directory-facing and memory-facing fields come straight from registers so
  // they are stable for the whole transaction.
  assign dir_index      = idx_q;
  assign dir_next_tag   = tag_q;
  assign dir_next_state = nst_q;
  assign mem_cmd        = cmd_q;
  assign mem_addr       = maddr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tag_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      hit_q   <= 1'b0;
      cmd_q   <= CMD_READ_S;
      nst_q   <= ST_I;
      maddr_q <= '0;
    end else begin
      state   <= state_nxt;
      hit_q   <= hit_nxt;
      cmd_q   <= cmd_nxt;
      nst_q   <= nst_nxt;
      maddr_q <= maddr_nxt;
      if (state == IDLE && req_valid) begin
        tag_q   <= req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
        idx_q   <= req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
        write_q <= req_write;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_q;
    cmd_nxt   = cmd_q;
    nst_nxt   = nst_q;
    maddr_nxt = maddr_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_hit   = 1'b0;
    mem_valid = 1'b0;
    dir_write = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          hit_nxt   = 1'b0;
          state_nxt = READ;
        end
      end
      // Directory read data lands one cycle after the index settles.
      READ: state_nxt = CMP;
      CMP: begin
        if (line_hit && (!write_q || dir_current_state == ST_M)) begin
          hit_nxt   = 1'b1;
          state_nxt = RESP;
        end else if (line_hit && dir_current_state == ST_E) begin
          // Silent E->M promotion: no coherence traffic needed.
          hit_nxt   = 1'b1;
          nst_nxt   = ST_M;
          state_nxt = UPDATE;
        end else if (line_hit) begin
          cmd_nxt   = CMD_UPGRADE;
          maddr_nxt = line_addr;
          state_nxt = CMD;
        end else if (dir_current_state == ST_M) begin
          // Dirty victim goes out first; the fill is issued after it completes.
          cmd_nxt   = CMD_WRITEBACK;
          maddr_nxt = victim_addr;
          state_nxt = CMD;
        end else begin
          cmd_nxt   = fill_cmd;
          maddr_nxt = line_addr;
          state_nxt = CMD;
        end
      end
      CMD: begin
        mem_valid = 1'b1;
        if (mem_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_done) begin
          if (cmd_q == CMD_WRITEBACK) begin
            cmd_nxt   = fill_cmd;
            maddr_nxt = line_addr;
            state_nxt = CMD;
          end else begin
            // Only a shared read can come back non-exclusive.
            if (cmd_q == CMD_READ_S) nst_nxt = mem_excl ? ST_E : ST_S;
            else                     nst_nxt = ST_M;
            state_nxt = UPDATE;
          end
        end
      end
      UPDATE: begin
        dir_write = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Bench for cache_lookup_ctrl: directory and memory environment, transaction-level reference model, per-cycle compare.
// Latency: expectations are per transaction; hit paths also check response latency.
// Backpressure: mem_ready and rsp_ready are throttled randomly or held low on purpose.
module tb_cache_lookup_ctrl;
  localparam int AW = 32;
  localparam int OW = 5;
  localparam int IW = 7;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic [IW-1:0] dir_index;
  logic [TW-1:0] dir_next_tag;
  logic [1:0]    dir_next_state;
  logic          dir_write;
  logic [TW-1:0] dir_current_tag;
  logic [1:0]    dir_current_state;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic          mem_done = 1'b0;
  logic          mem_excl = 1'b0;

  always #5 clk = ~clk;

  cache_lookup_ctrl #(.ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .dir_index(dir_index), .dir_next_tag(dir_next_tag), .dir_next_state(dir_next_state),
    .dir_write(dir_write), .dir_current_tag(dir_current_tag), .dir_current_state(dir_current_state),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_excl(mem_excl)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- directory environment ----------------
  bit   [TW-1:0] dtag [128];
  bit   [1:0]    dst  [128];
  logic          pl_en = 1'b0;
  logic [IW-1:0] pl_idx = '0;
  logic [TW-1:0] pl_tag = '0;
  logic [1:0]    pl_st  = '0;

  always @(posedge clk) begin
    dir_current_tag   <= dtag[dir_index];
    dir_current_state <= dst[dir_index];
    if (dir_write) begin
      dtag[dir_index] <= dir_next_tag;
      dst[dir_index]  <= dir_next_state;
    end else if (pl_en) begin
      dtag[pl_idx] <= pl_tag;
      dst[pl_idx]  <= pl_st;
    end
  end

  // ---------------- memory responder ----------------
  int hs_cnt    = 0;   // handshakes observed by the compare process
  int hs_taken  = 0;
  int hold_seq  = 0;   // driver bumps this to request a mem_ready stall
  int hold_n    = 0;
  int hold_tk   = 0;
  int rdy_left  = 0;
  bit rnd_rdy   = 1'b0;
  bit stray_en  = 1'b0;
  int excl_mode = 0;   // 0 random, 1 force 0, 2 force 1
  bit outst     = 1'b0;
  int dly       = 0;

  always @(posedge clk) begin
    #1;
    mem_done = 1'b0;
    if (hold_seq != hold_tk) begin
      hold_tk  = hold_seq;
      rdy_left = hold_n;
    end
    if (mem_valid && rdy_left > 0) begin
      mem_ready = 1'b0;
      rdy_left--;
    end else begin
      mem_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
    end
    if (!rst) begin
      outst    = 1'b0;
      hs_taken = hs_cnt;
    end else begin
      if (hs_cnt != hs_taken) begin
        hs_taken = hs_cnt;
        outst    = 1'b1;
        dly      = $urandom_range(0, 3);
      end
      if (outst) begin
        if (dly == 0) begin
          mem_done = 1'b1;
          mem_excl = (excl_mode == 0) ? 1'($urandom % 2) : (excl_mode == 2);
          outst    = 1'b0;
        end else begin
          dly--;
        end
      end else if (stray_en && ($urandom % 6) == 0) begin
        mem_done = 1'b1;
        mem_excl = 1'($urandom % 2);
      end
    end
  end

  // ---------------- reference model + compare ----------------
  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
  } mc_t;

  mc_t           expq[$];
  bit            busy = 1'b0;
  bit            was_busy;
  bit            awaiting = 1'b0;
  bit            wr_pend = 1'b0;
  bit            wr_unres = 1'b0;
  logic [1:0]    hs_cmd = '0;
  logic [IW-1:0] e_idx;
  logic [TW-1:0] e_tag;
  logic [1:0]    e_wst;
  bit            e_hit;
  int            e_lat;
  int            cnt;
  // per-transaction observations, used by the hand-computed checks
  int            obs_ncmd, obs_wr_cnt, obs_rsp, obs_lat, obs_mv;
  logic [1:0]    obs_cmd [2];
  logic [AW-1:0] obs_addr [2];
  logic [TW-1:0] obs_wr_tag;
  logic [1:0]    obs_wr_state;
  logic          obs_hit;
  // model scratch
  logic [TW-1:0] m_t, m_ct;
  logic [IW-1:0] m_i;
  logic [1:0]    m_cs;
  bit            m_h;

  always @(negedge clk) begin
    if (!rst) begin
      busy     = 1'b0;
      awaiting = 1'b0;
      wr_pend  = 1'b0;
      wr_unres = 1'b0;
      expq.delete();
    end else begin
      was_busy = busy;
      check("req_ready", req_ready, !busy);
      if (!busy) begin
        check("idle_quiet", {mem_valid, dir_write, rsp_valid}, 3'b000);
      end else begin
        cnt++;
        check("dir_index", dir_index, e_idx);
        // completion is handled before a same-cycle handshake so a stray pulse is never credited
        if (mem_done && awaiting) begin
          awaiting = 1'b0;
          if (wr_unres && hs_cmd == 2'd0) begin
            e_wst    = mem_excl ? 2'd2 : 2'd1;
            wr_unres = 1'b0;
          end
        end
        if (mem_valid) begin
          obs_mv++;
          if (expq.size() == 0) begin
            check("mem_unexpected", 1, 0);
          end else begin
            check("mem_cmd", mem_cmd, expq[0].cmd);
            check("mem_addr", mem_addr, expq[0].addr);
            if (mem_ready) begin
              hs_cmd = expq[0].cmd;
              if (obs_ncmd < 2) begin
                obs_cmd[obs_ncmd]  = mem_cmd;
                obs_addr[obs_ncmd] = mem_addr;
              end
              obs_ncmd++;
              void'(expq.pop_front());
              awaiting = 1'b1;
            end
          end
          if (mem_ready) hs_cnt++;
        end
        if (dir_write) begin
          check("wr_order", {wr_pend, wr_unres, expq.size() == 0, awaiting}, 4'b1010);
          check("wr_tag", dir_next_tag, e_tag);
          check("wr_state", dir_next_state, e_wst);
          wr_pend      = 1'b0;
          obs_wr_cnt++;
          obs_wr_tag   = dir_next_tag;
          obs_wr_state = dir_next_state;
        end
        if (rsp_valid) begin
          check("rsp_order", {wr_pend, expq.size() == 0, awaiting}, 3'b010);
          check("rsp_hit", rsp_hit, e_hit);
          if (obs_rsp == 0) begin
            obs_lat = cnt - 1;
            if (e_lat >= 0) check("rsp_latency", cnt - 1, e_lat);
          end
          obs_rsp++;
          if (rsp_ready) begin
            busy    = 1'b0;
            obs_hit = rsp_hit;
          end
        end
      end
      if (req_valid && req_ready && !was_busy) begin
        m_t  = req_addr[AW-1 -: TW];
        m_i  = req_addr[OW +: IW];
        m_ct = dtag[m_i];
        m_cs = dst[m_i];
        m_h  = (m_cs != 2'd0) && (m_ct == m_t);
        busy = 1'b1; cnt = 0; e_idx = m_i; e_tag = m_t; e_lat = -1;
        expq.delete(); wr_pend = 1'b0; wr_unres = 1'b0; awaiting = 1'b0;
        obs_ncmd = 0; obs_wr_cnt = 0; obs_rsp = 0; obs_mv = 0; obs_lat = -1;
        if (m_h && (!req_write || m_cs == 2'd3)) begin
          e_hit = 1'b1; e_lat = 2;
        end else if (m_h && m_cs == 2'd2) begin
          e_hit = 1'b1; e_lat = 3; wr_pend = 1'b1; e_wst = 2'd3;
        end else if (m_h) begin
          e_hit = 1'b0; wr_pend = 1'b1; e_wst = 2'd3;
          expq.push_back({2'd2, m_t, m_i, 5'd0});
        end else begin
          e_hit = 1'b0; wr_pend = 1'b1;
          if (m_cs == 2'd3) expq.push_back({2'd3, m_ct, m_i, 5'd0});
          expq.push_back({req_write ? 2'd1 : 2'd0, m_t, m_i, 5'd0});
          if (req_write) e_wst = 2'd3;
          else           wr_unres = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic preload(input logic [IW-1:0] i, input logic [TW-1:0] t, input logic [1:0] s);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = i; pl_tag = t; pl_st = s;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic send_req(input logic [AW-1:0] a, input bit w, output bit acc);
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_write = w; acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic txn(input logic [AW-1:0] a, input bit w, input int hold);
    bit acc, done;
    int held;
    send_req(a, w, acc);
    if (!acc) return;
    done = 1'b0; held = 0;
    rsp_ready = (hold == 0);
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) done = 1'b1;
      else if (rsp_valid)         held++;
      @(posedge clk); #1;
      rsp_ready = !done && (held >= hold);
      // requests offered while busy must be ignored
      req_valid = !done && 1'($urandom % 2);
      req_addr  = $urandom;
    end
    req_valid = 1'b0;
    if (!done) check("rsp_timeout", 0, 1);
  endtask

  logic [TW-1:0] tpool [4] = '{20'h12345, 20'h00001, 20'h0ABCD, 20'hFFFFF};
  logic [IW-1:0] ipool [4] = '{7'd0, 7'd1, 7'd5, 7'd127};

  initial begin
    bit acc, seen;
    rst = 1'b0; req_valid = 1'b1; req_addr = 32'h123450A0; req_write = 1'b0; rsp_ready = 1'b0;
    excl_mode = 1;
    repeat (3) @(negedge clk);
    check("rst_ready", {req_ready, rsp_valid, rsp_hit, dir_write, mem_valid}, 5'b10000);
    check("rst_dir", {dir_index, dir_next_tag, dir_next_state}, 0);
    check("rst_mem", {mem_cmd, mem_addr}, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);

    // load hit in E
    preload(7'd5, 20'h12345, 2'd2);
    txn(32'h123450A0, 1'b0, 0);
    check("e_load_hit", obs_hit, 1'b1);
    check("e_load_lat", obs_lat, 2);
    check("e_load_nowr", obs_wr_cnt, 0);
    // store hit in E promotes to M
    txn(32'h123450A0, 1'b1, 0);
    check("e_store_wr", {obs_wr_cnt[7:0], obs_wr_tag, obs_wr_state}, {8'd1, 20'h12345, 2'd3});
    check("e_store_hit", {obs_hit, obs_ncmd[7:0]}, {1'b1, 8'd0});
    check("e_store_lat", obs_lat, 3);
    // dirty victim: writeback then shared read
    preload(7'd5, 20'h00001, 2'd3);
    txn(32'h123450A0, 1'b0, 0);
    check("wb_ncmd", obs_ncmd, 2);
    check("wb_cmd0", {obs_cmd[0], obs_addr[0]}, {2'd3, 32'h000010A0});
    check("wb_cmd1", {obs_cmd[1], obs_addr[1]}, {2'd0, 32'h123450A0});
    check("wb_wr", {obs_wr_tag, obs_wr_state}, {20'h12345, 2'd1});
    check("wb_hit", obs_hit, 1'b0);
    // store hit in S with mem_ready stalled 3 cycles
    preload(7'd5, 20'h12345, 2'd1);
    hold_n = 3; hold_seq++;
    txn(32'h123450A0, 1'b1, 0);
    check("upg_cmd", {obs_ncmd[7:0], obs_cmd[0], obs_addr[0]}, {8'd1, 2'd2, 32'h123450A0});
    check("upg_mv_cycles", obs_mv, 4);
    check("upg_wr", {obs_wr_cnt[7:0], obs_wr_state}, {8'd1, 2'd3});
    check("upg_hit", obs_hit, 1'b0);
    // response held off 4 cycles with stray completions around
    stray_en = 1'b1;
    txn(32'h123450A0, 1'b0, 4);
    check("hold_rsp_cycles", obs_rsp, 5);
    check("hold_hit", obs_hit, 1'b1);
    repeat (20) @(negedge clk);
    check("stray_idle_ready", req_ready, 1'b1);

    // reset in the middle of a miss abandons it without a directory write
    stray_en = 1'b0;
    preload(7'd3, 20'h0ABCD, 2'd3);
    send_req({20'h11111, 7'd3, 5'd0}, 1'b0, acc);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_valid) seen = 1'b1;
    end
    check("midop_mem_valid", seen, 1'b1);
    @(posedge clk); #3;
    rst = 1'b0; #1;
    check("midop_rst_ctl", {req_ready, rsp_valid, mem_valid, dir_write}, 4'b1000);
    check("midop_rst_regs", {mem_addr, dir_index, mem_cmd, dir_next_state}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("midop_dir_kept", {dtag[3], dst[3]}, {20'h0ABCD, 2'd3});

    // randomized traffic
    rnd_rdy = 1'b1; stray_en = 1'b1; excl_mode = 0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom % 3 == 0)
        preload(ipool[$urandom % 4], tpool[$urandom % 4], 2'($urandom % 4));
      txn({tpool[$urandom % 4], ipool[$urandom % 4], 5'($urandom)}, 1'($urandom % 2), $urandom % 4);
    end
    repeat (5) @(negedge clk);
    check("end_idle", req_ready, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_lookup_ctrl.md
Name: cache_lookup_ctrl

Overview:
Per-core cache lookup controller that sits directly upstream of the cache directory and drives one directory port (index / next_tag / next_state / write, reading back current_tag / current_state). It accepts core requests, reads the directory, checks tag and line state, and responds on a hit. On a miss, upgrade or dirty eviction it sequences memory/coherence commands, then writes the new tag and state back to the directory.

Parameters:
ADDR_WIDTH, 32, request address width
OFFSET_WIDTH, 5, line offset bits (ignored by this block)
INDEX_WIDTH, 7, directory index bits = addr[OFFSET_WIDTH +: INDEX_WIDTH]
TAG_WIDTH, 20, tag bits = addr[ADDR_WIDTH-1 -: TAG_WIDTH]; ADDR_WIDTH = TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  core request valid
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_WIDTH  request address
req_write  in  1  1 = store, 0 = load
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_hit  out  1  1 = served without memory command
dir_index  out  INDEX_WIDTH  directory index
dir_next_tag  out  TAG_WIDTH  tag to write
dir_next_state  out  2  state to write
dir_write  out  1  directory write strobe
dir_current_tag  in  TAG_WIDTH  stored tag
dir_current_state  in  2  stored state
mem_valid  out  1  memory command valid
mem_ready  in  1  memory accepts command
mem_cmd  out  2  0 READ_S, 1 READ_X, 2 UPGRADE, 3 WRITEBACK
mem_addr  out  ADDR_WIDTH  line address (offset bits zero)
mem_done  in  1  one-cycle completion pulse for the outstanding command
mem_excl  in  1  sampled with mem_done on READ_S: 1 = granted exclusive

Behaviour:
- Line states: I=0, S=1, E=2, M=3. Directory read is synchronous: data is valid the cycle after dir_index is stable; write takes effect at the clk edge with dir_write=1.
- Reset (rst=0, async): state IDLE; req_ready=1; rsp_valid, rsp_hit, dir_write, mem_valid=0; dir_index, dir_next_tag, dir_next_state, mem_cmd, mem_addr=0. Reset mid-operation abandons the transaction; no directory write is issued.
- dir_index, dir_next_tag, mem_addr are driven from the latched request register, so they are stable for the whole transaction.
- FSM:
  - IDLE: req_ready=1; on req_valid&&req_ready, latch addr/write -> READ.
  - READ: one wait cycle -> CMP.
  - CMP: hit = state!=I && tag match.
    - Load hit, or store hit in M -> RESP, rsp_hit=1, no write.
    - Store hit in E -> UPDATE with next_state=M, rsp_hit=1.
    - Store hit in S -> CMD with UPGRADE.
    - Miss with victim M -> CMD with WRITEBACK to {current_tag, index, 0}.
    - Other miss -> CMD with READ_S (load) or READ_X (store).
  - CMD: mem_valid=1, holding cmd/addr until mem_ready -> WAIT.
  - WAIT: on mem_done:
    - WRITEBACK -> CMD with the fill command for the latched address.
    - Otherwise -> UPDATE. next_state is M for a store; E if mem_excl else S for READ_S; M for UPGRADE.
  - UPDATE: dir_write=1 for exactly one cycle with latched tag -> RESP.
  - RESP: rsp_valid=1 held until rsp_ready -> IDLE. rsp_hit=0 on any path through CMD.
- Hit latency: rsp_valid is asserted 2 cycles after acceptance (3 for store-to-E). req_ready=0 outside IDLE (one outstanding transaction).
- mem_done in any state other than WAIT is ignored. mem_excl is ignored for non-READ_S commands.

Test Plan:
- Reset with req_valid=1 -> all outputs at reset values. After release, req_ready=1 and no dir_write occurs.
- Preload idx 5: tag 0x12345, state E. Load 0x12345_0A0 -> rsp_valid exactly 2 cycles after acceptance, rsp_hit=1, dir_write never asserted.
- Store to the same line -> one dir_write with tag 0x12345, state 3, before rsp_valid. rsp_hit=1, no mem_valid.
- Idx 5 holds tag 0x00001 in M. Load 0x12345_0A0 -> WRITEBACK to 0x000010A0, then READ_S to 0x123450A0. mem_done with mem_excl=0 -> dir_write state 1, rsp_hit=0.
- Store hit in S with mem_ready low 3 cycles -> mem_valid/cmd=2/addr held stable. After mem_done: dir_write state 3, then response.
- rsp_ready held low 4 cycles -> rsp_valid stays high, req_ready=0. Stray mem_done pulses in IDLE/RESP -> no state change.
